// File: rtl/adc_avg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : adc_avg_capture
//  Description : Mean-magnitude capture of offset-binary I/Q ADC samples.
//                Accumulates |x| over 2^LOG2_N used samples of the selected
//                channel and publishes the mean as adc_reg with a one-cycle
//                adc_ready strobe. Maintains a sticky clip flag.
//                Optional macro ADC_PEAK_EN adds a running peak |x| register
//                on adc_peak; when undefined adc_peak is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_capture #(
    parameter int LOG2_N = 4,   // log2 of samples per block (1..8)
    parameter int CHAN   = 0    // 0 = I only, 1 = Q only, 2 = both
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] adc_data,
    input  logic       adc_valid,
    input  logic       adc_iq,
    input  logic       clip_clr,
    output logic [7:0] adc_reg,
    output logic       adc_ready,
    output logic       clip,
    output logic [7:0] adc_peak
);

    // Accumulator is wide enough for 2^LOG2_N magnitudes of up to 127.
    localparam int c_ACC_W = 7 + LOG2_N;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_ACC_W-1:0]   r_acc;
    logic [LOG2_N-1:0]    r_cnt;

    logic                 w_chan_match;
    logic                 w_used;
    logic                 w_clip_samp;
    logic [7:0]           w_s;
    logic [6:0]           w_mag;
    logic [c_ACC_W-1:0]   w_sum;
    logic                 w_last;

    // Channel filter, sample conversion to saturated magnitude, block sum.
    always_comb begin
        if (CHAN == 0) begin
            w_chan_match = ~adc_iq;
        end else if (CHAN == 1) begin
            w_chan_match = adc_iq;
        end else begin
            w_chan_match = 1'b1;
        end

        w_used      = adc_valid & en & w_chan_match;
        w_clip_samp = (adc_data == 8'h00) | (adc_data == 8'hFF);

        // Two's-complement view of the offset-binary sample; -128 saturates to 127.
        w_s = adc_data ^ 8'h80;
        if (w_s[7]) begin
            w_mag = (w_s == 8'h80) ? 7'h7F : (~w_s[6:0] + 7'd1);
        end else begin
            w_mag = w_s[6:0];
        end

        w_sum  = r_acc + c_ACC_W'(w_mag);
        w_last = (r_cnt == {LOG2_N{1'b1}});
    end

    // Block FSM: accumulate while running, publish mean on the final sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            adc_reg   <= 8'h00;
            adc_ready <= 1'b0;
        end else begin
            adc_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        // Partial block is dropped; adc_reg keeps the last mean.
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (w_used) begin
                        if (w_last) begin
                            adc_reg   <= {1'b0, w_sum[c_ACC_W-1:LOG2_N]};
                            adc_ready <= 1'b1;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + LOG2_N'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky clip flag; a clipping sample overrides a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip <= 1'b0;
        end else if (w_used && w_clip_samp) begin
            clip <= 1'b1;
        end else if (clip_clr) begin
            clip <= 1'b0;
        end
    end

`ifdef ADC_PEAK_EN
    // Running peak magnitude; a clear with a same-cycle sample restarts from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_peak <= 8'h00;
        end else if (clip_clr) begin
            adc_peak <= w_used ? {1'b0, w_mag} : 8'h00;
        end else if (w_used && ({1'b0, w_mag} > adc_peak)) begin
            adc_peak <= {1'b0, w_mag};
        end
    end
`else
    assign adc_peak = 8'h00;
`endif

endmodule
`default_nettype wire
